sequence_input_tracker: RTL

- Producer side of the button-symbol display interface: generates and holds the 8-symbol challenge sequence and drives the per-slot 4-bit symbol words consumed by the graphics controller.
- Decodes player pad presses, advances progress on correct presses, and issues strikes on wrong ones.
- Reports solved/failed status to the bomb stage logic.

---
 rtl/sequence_input_tracker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sequence_input_tracker.sv
// sequence_input_tracker: holds the 8-symbol challenge, decodes pad presses,
// tracks progress and strikes, and reports solved/failed to the stage logic.
module sequence_input_tracker #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MAX_STRIKES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        seq_wr,
  input  logic [23:0] seq_data,
  input  logic [5:0]  pad,
  output logic [3:0]  buttons [0:7],
  output logic [3:0]  progress,
  output logic        strike,
  output logic [2:0]  strike_count,
  output logic        solved,
  output logic        failed
);

  // A zero seed would lock the LFSR, so fall back to the default pattern.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]  MAX_S    = 4'(MAX_STRIKES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_SOLVED,
    ST_FAILED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  buttons_q [0:7];
  logic [3:0]  buttons_d [0:7];
  logic [3:0]  progress_q, progress_d;
  logic        strike_q, strike_d;
  logic [2:0]  strike_cnt_q, strike_cnt_d;
  logic        solved_q, solved_d;
  logic        failed_q, failed_d;
  logic [5:0]  pad_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  load_idx_q, load_idx_d;

  logic [5:0]  rise;
  logic        press_valid;
  logic [2:0]  press_code;

  // Raw 3-bit values 6 and 7 fold back onto codes 0 and 1.
  function automatic logic [2:0] to_code(input logic [2:0] v);
    return (v >= 3'd6) ? v - 3'd6 : v;
  endfunction

  // LFSR next value: taps 16,14,13,11, shifting every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Press decode: exactly one rising pad bit is a press; its index is the code.
  always_comb begin
    rise        = pad & ~pad_q;
    press_valid = (rise != 6'h00) && ((rise & (rise - 6'd1)) == 6'h00);
    press_code  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (rise[i]) press_code = 3'(i);
    end
  end

  // Next-state and output logic; seq_wr outranks start, both override any state.
  always_comb begin
    state_d      = state_q;
    buttons_d    = buttons_q;
    progress_d   = progress_q;
    strike_d     = 1'b0;
    strike_cnt_d = strike_cnt_q;
    load_idx_d   = load_idx_q;

    if (seq_wr) begin
      for (int i = 0; i < 8; i++) buttons_d[i] = {1'b0, to_code(seq_data[3*i +: 3])};
      progress_d   = 4'd0;
      strike_cnt_d = 3'd0;
      state_d      = ST_ARMED;
    end else if (start) begin
      for (int i = 0; i < 8; i++) buttons_d[i][3] = 1'b0;
      progress_d   = 4'd0;
      strike_cnt_d = 3'd0;
      load_idx_d   = 3'd0;
      state_d      = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          buttons_d[load_idx_q] = {1'b0, to_code(lfsr_q[2:0])};
          load_idx_d            = load_idx_q + 3'd1;
          if (load_idx_q == 3'd7) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (press_valid) begin
            if (press_code == buttons_q[progress_q[2:0]][2:0]) begin
              buttons_d[progress_q[2:0]][3] = 1'b1;
              progress_d                    = progress_q + 4'd1;
              if (progress_q == 4'd7) state_d = ST_SOLVED;
            end else begin
              strike_d     = 1'b1;
              strike_cnt_d = (strike_cnt_q == 3'd7) ? 3'd7 : strike_cnt_q + 3'd1;
              progress_d   = 4'd0;
              for (int i = 0; i < 8; i++) buttons_d[i][3] = 1'b0;
              if (({1'b0, strike_cnt_q} + 4'd1) == MAX_S) state_d = ST_FAILED;
            end
          end
        end
        default: ;
      endcase
    end

    solved_d = (state_d == ST_SOLVED);
    failed_d = (state_d == ST_FAILED);
  end

  // State and output registers; pad history resets high so held buttons give no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      buttons_q    <= '{default: 4'h0};
      progress_q   <= 4'd0;
      strike_q     <= 1'b0;
      strike_cnt_q <= 3'd0;
      solved_q     <= 1'b0;
      failed_q     <= 1'b0;
      pad_q        <= 6'h3F;
      lfsr_q       <= SEED_EFF;
      load_idx_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      buttons_q    <= buttons_d;
      progress_q   <= progress_d;
      strike_q     <= strike_d;
      strike_cnt_q <= strike_cnt_d;
      solved_q     <= solved_d;
      failed_q     <= failed_d;
      pad_q        <= pad;
      lfsr_q       <= lfsr_d;
      load_idx_q   <= load_idx_d;
    end
  end

  assign buttons      = buttons_q;
  assign progress     = progress_q;
  assign strike       = strike_q;
  assign strike_count = strike_cnt_q;
  assign solved       = solved_q;
  assign failed       = failed_q;

endmodule
